// File: rtl/mux_4x1_behav.sv
// 4-to-1 steering mux: a combinational output plus registered copies of the
// selected data and a one-cycle pulse that flags a change of select value.
module mux_4x1_behav #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             sel1,
  input  logic             sel0,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_chg
);

  logic [1:0] sel;
  logic [1:0] sel_prev_q;
  logic       sel_chg_d;

  assign sel = {sel1, sel0};

  // An unknown select propagates as all-X in simulation; synthesis treats it as don't-care.
  always_comb begin
    out = 'x;
    case (sel)
      2'b00:   out = in0;
      2'b01:   out = in1;
      2'b10:   out = in2;
      2'b11:   out = in3;
      default: out = 'x;
    endcase
  end

  assign sel_chg_d = (sel != sel_prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      sel_prev_q <= 2'b00;
      sel_chg    <= 1'b0;
    end else begin
      out_q      <= out;
      sel_prev_q <= sel;
      sel_chg    <= sel_chg_d;
    end
  end

endmodule

// File: tb/tb_mux_4x1_behav.sv
// Bench for mux_4x1_behav (WIDTH=8): directed steps then random vectors,
// each compared against an array-indexed reference model.
module tb_mux_4x1_behav;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in0, in1, in2, in3;
  logic         sel1, sel0;
  logic [W-1:0] out, out_q;
  logic         sel_chg;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [W-1:0] m_in [4];
  logic [1:0]   m_prev_sel;
  logic [W-1:0] m_q;
  logic         m_chg;

  mux_4x1_behav #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .sel1(sel1), .sel0(sel0),
    .out(out), .out_q(out_q), .sel_chg(sel_chg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_out();
    logic [1:0] s;
    s = {sel1, sel0};
    if ($isunknown(s)) return 'x;
    return m_in[s];
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d, input logic [1:0] s);
    m_in[0] = a; m_in[1] = b; m_in[2] = c; m_in[3] = d;
    in0 = a; in1 = b; in2 = c; in3 = d;
    {sel1, sel0} = s;
  endtask

  task automatic check_out(input string tag);
    #1;
    check(tag, out, ref_out());
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_q"}, out_q, m_q);
    check({tag, "_chg"}, {7'b0, sel_chg}, {7'b0, m_chg});
  endtask

  // One rising edge: model predicts from values settled before the edge.
  task automatic tick(input string tag);
    logic [W-1:0] nq;
    logic         nc;
    logic [1:0]   s;
    s  = {sel1, sel0};
    nq = ref_out();
    nc = (s != m_prev_sel);
    @(posedge clk);
    if (rst_n) begin
      m_q = nq; m_chg = nc; m_prev_sel = s;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    m_q = '0; m_chg = 1'b0; m_prev_sel = 2'b00;
    #1;
    check_regs(tag);
    check({tag, "_out"}, out, ref_out());
    #1 rst_n = 1'b1;
  endtask

  initial begin
    m_prev_sel = 2'b00; m_q = '0; m_chg = 1'b0;
    rst_n = 1'b0;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    #1;
    check_regs("reset");
    check("reset_q_const", out_q, 8'h00);

    // truth table, combinational path alive while reset is held
    drive(8'h01, 8'h00, 8'h00, 8'h00, 2'b00); check_out("tt_00");
    check("tt_00_const", out, 8'h01); #8;
    drive(8'h00, 8'h01, 8'h00, 8'h00, 2'b01); check_out("tt_01"); #9;
    drive(8'h00, 8'h00, 8'h01, 8'h00, 2'b10); check_out("tt_10"); #9;
    drive(8'h00, 8'h00, 8'h00, 8'h01, 2'b11); check_out("tt_11");
    check("tt_11_const", out, 8'h01); #9;
    rst_n = 1'b1;

    // isolation: unselected inputs toggle, sel=10 with in2=0
    drive(8'hFF, 8'hFF, 8'h00, 8'hFF, 2'b10); check_out("iso_a");
    tick("iso_a");
    drive(8'h00, 8'h00, 8'h00, 8'h00, 2'b10); check_out("iso_b");
    tick("iso_b");
    drive(8'h5A, 8'hC3, 8'h00, 8'h3C, 2'b10); check_out("iso_c");
    tick("iso_c");
    check("iso_q_const", out_q, 8'h00);

    // registered path
    drive(8'h00, 8'hA5, 8'h00, 8'h00, 2'b01); check_out("reg_comb");
    check("reg_comb_const", out, 8'hA5);
    check("reg_before", out_q, 8'h00);
    tick("reg_edge");
    check("reg_after_const", out_q, 8'hA5);

    // asynchronous reset mid-stream, then reload on release
    reset_pulse("arst");
    check("arst_out_const", out, 8'hA5);
    tick("arst_rel");
    check("arst_rel_q_const", out_q, 8'hA5);
    check("arst_rel_chg_const", {7'b0, sel_chg}, 8'h01);

    // select-change pulse
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'b00);
    tick("chg_prime");
    tick("chg_h1"); check("chg_h1_const", {7'b0, sel_chg}, 8'h00);
    tick("chg_h2"); check("chg_h2_const", {7'b0, sel_chg}, 8'h00);
    tick("chg_h3"); check("chg_h3_const", {7'b0, sel_chg}, 8'h00);
    {sel1, sel0} = 2'b11;
    tick("chg_sw"); check("chg_sw_const", {7'b0, sel_chg}, 8'h01);
    tick("chg_after"); check("chg_after_const", {7'b0, sel_chg}, 8'h00);

    // unknown select
    sel1 = 1'bx; check_out("selx");
    sel1 = 1'b0; check_out("selx_restore");
    check("selx_restore_const", out, 8'h22);
    tick("selx_tick");

    // random stimulus
    for (int i = 0; i < 300; i++) begin
      drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 2'($urandom));
      check_out("rnd_a");
      if ($urandom_range(0, 3) == 0) begin
        drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 2'($urandom));
        check_out("rnd_b");
      end
      if ($urandom_range(0, 19) == 0) reset_pulse("rnd_rst");
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
